// File: rtl/sobel_pkg.sv
// Shared types and saturating arithmetic helpers for the Sobel output back end.
package sobel_pkg;

  typedef enum logic [1:0] {
    MODE_MAG    = 2'd0,
    MODE_THRESH = 2'd1,
    MODE_GX_ABS = 2'd2,
    MODE_GY_ABS = 2'd3
  } mode_e;

  typedef enum logic {
    SER_IDLE = 1'b0,
    SER_EMIT = 1'b1
  } ser_state_e;

  // Working width for gradient arithmetic; gradients up to 31 bits fit with headroom.
  localparam int unsigned ABS_W = 32;

  // |v| for a w-bit signed value, with the most negative code clamped to 2**(w-1)-1.
  function automatic logic [ABS_W-1:0] sat_abs(input logic signed [ABS_W-1:0] v, input int w);
    logic [ABS_W-1:0] lim;
    logic [ABS_W-1:0] mag;
    lim = (ABS_W'(1) << (w - 1)) - ABS_W'(1);
    mag = v[ABS_W-1] ? ABS_W'(-v) : ABS_W'(v);
    return (mag > lim) ? lim : mag;
  endfunction

  function automatic logic [ABS_W-1:0] sat_to(input logic [ABS_W-1:0] v, input int w);
    logic [ABS_W-1:0] lim;
    lim = (ABS_W'(1) << w) - ABS_W'(1);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/sobel_edge_out_if.sv
// Gradient input stream, runtime controls and byte output stream of the Sobel back end.
interface sobel_edge_out_if #(
  parameter int WIDTH_P  = 8,
  parameter int GRAD_W_P = 2 * WIDTH_P
);
  logic                       valid_i;
  logic                       ready_o;
  logic signed [GRAD_W_P-1:0] gx_i;
  logic signed [GRAD_W_P-1:0] gy_i;
  logic [1:0]                 mode_i;
  logic [WIDTH_P-1:0]         thresh_i;
  logic                       valid_o;
  logic                       ready_i;
  logic [WIDTH_P-1:0]         data_o;
  logic                       sof_o;
  logic                       eol_o;
  logic                       frame_done_o;

  modport master (
    output valid_i, gx_i, gy_i, mode_i, thresh_i, ready_i,
    input  ready_o, valid_o, data_o, sof_o, eol_o, frame_done_o
  );

  modport slave (
    input  valid_i, gx_i, gy_i, mode_i, thresh_i, ready_i,
    output ready_o, valid_o, data_o, sof_o, eol_o, frame_done_o
  );
endinterface

// File: rtl/sobel_ch_serializer.sv
// Stage 2: replays one computed pixel as CHANNELS_P identical beats, with sof/eol on the
// first/last beat and a frame_done pulse after the final beat of the frame.
module sobel_ch_serializer
  import sobel_pkg::*;
#(
  parameter int WIDTH_P    = 8,
  parameter int CHANNELS_P = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_valid,
  input  logic [WIDTH_P-1:0] load_data,
  input  logic               load_sof,
  input  logic               load_eol,
  input  logic               load_last,
  output logic               load_ready,
  input  logic               ready_i,
  output logic               valid_o,
  output logic [WIDTH_P-1:0] data_o,
  output logic               sof_o,
  output logic               eol_o,
  output logic               frame_done_o
);

  localparam int BEAT_W = (CHANNELS_P > 1) ? $clog2(CHANNELS_P) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(CHANNELS_P - 1);

  ser_state_e         state_r, state_s;
  logic [BEAT_W-1:0]  beat_r, beat_s, beat_inc_s;
  logic [WIDTH_P-1:0] data_r, data_s;
  logic               eol_flag_r, eol_flag_s;
  logic               last_flag_r, last_flag_s;
  logic               sof_r, sof_s;
  logic               eol_r, eol_s;
  logic               done_r, done_s;
  logic               hs_s, final_s, load_s;

  assign hs_s       = (state_r == SER_EMIT) && ready_i;
  assign final_s    = hs_s && (beat_r == LAST_BEAT);
  assign load_ready = (state_r == SER_IDLE) || final_s;
  assign load_s     = load_valid && load_ready;
  assign beat_inc_s = beat_r + BEAT_W'(1);

  always_comb begin
    state_s     = state_r;
    beat_s      = beat_r;
    data_s      = data_r;
    eol_flag_s  = eol_flag_r;
    last_flag_s = last_flag_r;
    sof_s       = sof_r;
    eol_s       = eol_r;
    done_s      = final_s && last_flag_r;
    case (state_r)
      SER_IDLE: begin
        if (load_s) begin
          state_s     = SER_EMIT;
          beat_s      = '0;
          data_s      = load_data;
          eol_flag_s  = load_eol;
          last_flag_s = load_last;
          sof_s       = load_sof;
          eol_s       = load_eol && (LAST_BEAT == '0);
        end else begin
          state_s = SER_IDLE;
        end
      end
      SER_EMIT: begin
        // Back-to-back reload on the final beat keeps throughput at one pixel per CHANNELS_P cycles.
        if (load_s) begin
          state_s     = SER_EMIT;
          beat_s      = '0;
          data_s      = load_data;
          eol_flag_s  = load_eol;
          last_flag_s = load_last;
          sof_s       = load_sof;
          eol_s       = load_eol && (LAST_BEAT == '0);
        end else if (final_s) begin
          state_s = SER_IDLE;
          sof_s   = 1'b0;
          eol_s   = 1'b0;
        end else if (hs_s) begin
          beat_s = beat_inc_s;
          sof_s  = 1'b0;
          eol_s  = eol_flag_r && (beat_inc_s == LAST_BEAT);
        end else begin
          state_s = SER_EMIT;
        end
      end
      default: begin
        state_s = SER_IDLE;
        sof_s   = 1'b0;
        eol_s   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= SER_IDLE;
      beat_r      <= '0;
      data_r      <= '0;
      eol_flag_r  <= 1'b0;
      last_flag_r <= 1'b0;
      sof_r       <= 1'b0;
      eol_r       <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      beat_r      <= beat_s;
      data_r      <= data_s;
      eol_flag_r  <= eol_flag_s;
      last_flag_r <= last_flag_s;
      sof_r       <= sof_s;
      eol_r       <= eol_s;
      done_r      <= done_s;
    end
  end

  assign valid_o      = (state_r == SER_EMIT);
  assign data_o       = data_r;
  assign sof_o        = sof_r;
  assign eol_o        = eol_r;
  assign frame_done_o = done_r;

endmodule

// File: rtl/sobel_edge_out.sv
// Sobel back end: edge value selection, border zeroing and frame/line tagging (stage 1),
// followed by the per-channel byte serializer (stage 2).
module sobel_edge_out
  import sobel_pkg::*;
#(
  parameter int WIDTH_P    = 8,
  parameter int GRAD_W_P   = 2 * WIDTH_P,
  parameter int LINE_W_P   = 640,
  parameter int FRAME_H_P  = 480,
  parameter int CHANNELS_P = 3
) (
  input logic             clk_i,
  input logic             rst_i,
  sobel_edge_out_if.slave bus
);

  localparam int COL_W = $clog2(LINE_W_P);
  localparam int ROW_W = $clog2(FRAME_H_P);
  localparam logic [WIDTH_P-1:0] PIX_MAX = '1;

  logic               run_r;
  logic [COL_W-1:0]   col_r;
  logic [ROW_W-1:0]   row_r;
  mode_e              mode_r, mode_s;
  logic [WIDTH_P-1:0] thresh_r, thresh_s;
  logic               s1_full_r, s1_sof_r, s1_eol_r, s1_last_r;
  logic [WIDTH_P-1:0] s1_data_r;

  logic               accept_s, xfer_s, load_ready_s;
  logic               at_origin_s, last_col_s, last_row_s, border_s;
  logic signed [ABS_W-1:0] gx_ext_s, gy_ext_s;
  logic [ABS_W-1:0]   ax_s, ay_s, mag_s;
  logic [WIDTH_P-1:0] mag_pix_s, value_s;

  assign bus.ready_o = run_r && (!s1_full_r || load_ready_s);
  assign accept_s    = bus.valid_i && bus.ready_o;
  assign xfer_s      = s1_full_r && load_ready_s;

  assign at_origin_s = (col_r == '0) && (row_r == '0);
  assign last_col_s  = (col_r == COL_W'(LINE_W_P - 1));
  assign last_row_s  = (row_r == ROW_W'(FRAME_H_P - 1));
  assign border_s    = (col_r == '0) || (row_r == '0) || last_col_s || last_row_s;

  // Pixel (0,0) sees the live controls; the rest of the frame uses the values latched there.
  assign mode_s   = at_origin_s ? mode_e'(bus.mode_i) : mode_r;
  assign thresh_s = at_origin_s ? bus.thresh_i : thresh_r;

  assign gx_ext_s  = ABS_W'(bus.gx_i);
  assign gy_ext_s  = ABS_W'(bus.gy_i);
  assign ax_s      = sat_abs(gx_ext_s, GRAD_W_P);
  assign ay_s      = sat_abs(gy_ext_s, GRAD_W_P);
  assign mag_s     = sat_to(ax_s + ay_s, WIDTH_P);
  assign mag_pix_s = WIDTH_P'(mag_s);

  always_comb begin
    value_s = '0;
    if (border_s) begin
      value_s = '0;
    end else begin
      case (mode_s)
        MODE_MAG:    value_s = mag_pix_s;
        MODE_THRESH: value_s = (mag_pix_s >= thresh_s) ? PIX_MAX : '0;
        MODE_GX_ABS: value_s = WIDTH_P'(sat_to(ax_s, WIDTH_P));
        MODE_GY_ABS: value_s = WIDTH_P'(sat_to(ay_s, WIDTH_P));
        default:     value_s = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      run_r     <= 1'b0;
      col_r     <= '0;
      row_r     <= '0;
      mode_r    <= MODE_MAG;
      thresh_r  <= '0;
      s1_full_r <= 1'b0;
      s1_data_r <= '0;
      s1_sof_r  <= 1'b0;
      s1_eol_r  <= 1'b0;
      s1_last_r <= 1'b0;
    end else begin
      run_r <= 1'b1;
      if (accept_s) begin
        if (last_col_s) begin
          col_r <= '0;
          row_r <= last_row_s ? '0 : row_r + ROW_W'(1);
        end else begin
          col_r <= col_r + COL_W'(1);
        end
        if (at_origin_s) begin
          mode_r   <= mode_s;
          thresh_r <= thresh_s;
        end
        s1_full_r <= 1'b1;
        s1_data_r <= value_s;
        s1_sof_r  <= at_origin_s;
        s1_eol_r  <= last_col_s;
        s1_last_r <= last_col_s && last_row_s;
      end else if (xfer_s) begin
        s1_full_r <= 1'b0;
      end
    end
  end

  sobel_ch_serializer #(
    .WIDTH_P   (WIDTH_P),
    .CHANNELS_P(CHANNELS_P)
  ) u_ser (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_valid  (s1_full_r),
    .load_data   (s1_data_r),
    .load_sof    (s1_sof_r),
    .load_eol    (s1_eol_r),
    .load_last   (s1_last_r),
    .load_ready  (load_ready_s),
    .ready_i     (bus.ready_i),
    .valid_o     (bus.valid_o),
    .data_o      (bus.data_o),
    .sof_o       (bus.sof_o),
    .eol_o       (bus.eol_o),
    .frame_done_o(bus.frame_done_o)
  );

endmodule

// File: tb/tb_sobel_edge_out.sv
// Directed and randomised bench for sobel_edge_out on a 4x3 frame with 3 channels.
module tb_sobel_edge_out;

  localparam int W  = 8;
  localparam int G  = 16;
  localparam int LW = 4;
  localparam int FH = 3;
  localparam int CH = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sobel_edge_out_if #(.WIDTH_P(W), .GRAD_W_P(G)) bus ();

  sobel_edge_out #(
    .WIDTH_P(W), .GRAD_W_P(G), .LINE_W_P(LW), .FRAME_H_P(FH), .CHANNELS_P(CH)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct packed {
    logic         sof;
    logic         eol;
    logic         last;
    logic [W-1:0] data;
  } beat_t;

  beat_t        sb[$];
  logic [W-1:0] got[$];
  int n_assert = 0;
  int n_fail   = 0;
  int m_col, m_row, m_mode, m_thr;
  int beats, sofs, eols, fds, nz;
  bit rand_rdy = 1'b0;
  bit rand_vld = 1'b0;
  bit exp_fd   = 1'b0;
  bit prev_stall = 1'b0;
  beat_t held;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int expv(input int gx, input int gy, input int mode, input int thr,
                              input int col, input int row);
    int ax, ay, m;
    if (col == 0 || row == 0 || col == LW - 1 || row == FH - 1) return 0;
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    if (ax > 32767) ax = 32767;
    if (ay > 32767) ay = 32767;
    m = ax + ay;
    if (m > 255) m = 255;
    case (mode)
      0: return m;
      1: return (m >= thr) ? 255 : 0;
      2: return (ax > 255) ? 255 : ax;
      3: return (ay > 255) ? 255 : ay;
      default: return 0;
    endcase
  endfunction

  // Scoreboard: model push on input handshake, pop/compare on output handshake.
  always @(negedge clk) begin
    beat_t e;
    int v;
    if (rst) begin
      sb.delete();
      m_col = 0; m_row = 0;
      prev_stall = 1'b0;
      exp_fd = 1'b0;
    end else begin
      if (exp_fd || bus.frame_done_o) chk("frame_done", 32'(bus.frame_done_o), 32'(exp_fd));
      if (bus.frame_done_o) fds++;
      exp_fd = 1'b0;
      if (prev_stall) begin
        chk("stall_valid", 32'(bus.valid_o), 32'd1);
        chk("stall_hold", {22'd0, bus.sof_o, bus.eol_o, bus.data_o}, {22'd0, held.sof, held.eol, held.data});
      end
      if (bus.valid_o && !bus.ready_i && sb.size() > CH) chk("ready_both_full", 32'(bus.ready_o), 32'd0);
      if (bus.valid_o && bus.ready_i) begin
        chk("queue_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("beat", {22'd0, bus.sof_o, bus.eol_o, bus.data_o}, {22'd0, e.sof, e.eol, e.data});
          got.push_back(bus.data_o);
          beats++;
          if (bus.sof_o) sofs++;
          if (bus.eol_o) eols++;
          if (bus.data_o != '0) nz++;
          exp_fd = e.last;
        end
      end
      if (bus.valid_i && bus.ready_o) begin
        if (m_col == 0 && m_row == 0) begin
          m_mode = int'(bus.mode_i);
          m_thr  = int'(bus.thresh_i);
        end
        v = expv(int'(bus.gx_i), int'(bus.gy_i), m_mode, m_thr, m_col, m_row);
        for (int b = 0; b < CH; b++) begin
          e.sof  = (m_col == 0 && m_row == 0 && b == 0);
          e.eol  = (m_col == LW - 1 && b == CH - 1);
          e.last = (m_col == LW - 1 && m_row == FH - 1 && b == CH - 1);
          e.data = W'(v);
          sb.push_back(e);
        end
        if (m_col == LW - 1) begin
          m_col = 0;
          m_row = (m_row == FH - 1) ? 0 : m_row + 1;
        end else begin
          m_col++;
        end
      end
      prev_stall = bus.valid_o && !bus.ready_i;
      held.sof  = bus.sof_o;
      held.eol  = bus.eol_o;
      held.last = 1'b0;
      held.data = bus.data_o;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      bus.ready_i = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input int gx, input int gy);
    bit ok;
    ok = 1'b0;
    if (rand_vld) begin
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk);
        #1;
      end
    end
    bus.gx_i = G'(gx);
    bus.gy_i = G'(gy);
    bus.valid_i = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (bus.ready_o) ok = 1'b1;
    end
    chk("accept", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
  endtask

  task automatic frame(input int mode0, input int thr0, input int mode1, input int thr1,
                       input int gx5, input int gy5, input int gx6, input int gy6,
                       input int fill, input bit lat);
    bus.mode_i   = 2'(mode0);
    bus.thresh_i = W'(thr0);
    for (int p = 0; p < LW * FH; p++) begin
      int gx, gy;
      gx = fill; gy = fill;
      if (p == 5) begin gx = gx5; gy = gy5; end
      if (p == 6) begin gx = gx6; gy = gy6; end
      send(gx, gy);
      if (p == 0) begin
        if (lat) begin
          @(negedge clk);
          chk("latency_t1", 32'(bus.valid_o), 32'd0);
          @(negedge clk);
          chk("latency_t2", 32'(bus.valid_o), 32'd1);
          @(posedge clk);
          #1;
        end
        bus.mode_i   = 2'(mode1);
        bus.thresh_i = W'(thr1);
      end
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 2000; n++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk("drain", 32'(sb.size()), 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_counts();
    beats = 0; sofs = 0; eols = 0; fds = 0; nz = 0;
    got.delete();
  endtask

  initial begin
    rst = 1'b1;
    bus.valid_i = 1'b0; bus.gx_i = '0; bus.gy_i = '0;
    bus.mode_i = 2'd0; bus.thresh_i = '0; bus.ready_i = 1'b1;
    clear_counts();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_valid", 32'(bus.valid_o), 32'd0);
      chk("rst_ready", 32'(bus.ready_o), 32'd0);
      chk("rst_outs", {28'd0, bus.sof_o, bus.eol_o, bus.frame_done_o, 1'b0}, 32'd0);
      chk("rst_data", 32'(bus.data_o), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_reset", 32'(bus.ready_o), 32'd1);

    // MAG on interior pixels, including saturation.
    frame(0, 0, 0, 0, -3, 4, -100, 200, 0, 1'b1);
    drain();
    chk("mag_7_b0", 32'(got[15]), 32'd7);
    chk("mag_7_b2", 32'(got[17]), 32'd7);
    chk("mag_sat_b0", 32'(got[18]), 32'd255);
    chk("mag_sat_b2", 32'(got[20]), 32'd255);
    chk("frameA_beats", 32'(beats), 32'd36);

    clear_counts();
    frame(0, 0, 0, 0, 10, 10, 10, 10, 10, 1'b0);
    drain();
    chk("full_beats", 32'(beats), 32'd36);
    chk("full_sof", 32'(sofs), 32'd1);
    chk("full_eol", 32'(eols), 32'd3);
    chk("full_done", 32'(fds), 32'd1);
    chk("full_nonzero", 32'(nz), 32'd6);
    chk("full_p5", 32'(got[15]), 32'd20);
    chk("full_p6", 32'(got[20]), 32'd20);

    // THRESH at 50; threshold lowered mid-frame must not apply yet.
    clear_counts();
    frame(1, 50, 1, 0, 20, 29, 20, 30, 0, 1'b0);
    drain();
    chk("thresh_below", 32'(got[16]), 32'd0);
    chk("thresh_at", 32'(got[19]), 32'd255);

    // GX_ABS with most negative gradient; mode switched to MAG mid-frame.
    clear_counts();
    frame(2, 0, 0, 0, -32768, 0, 5, 100, 0, 1'b0);
    drain();
    chk("gxabs_min", 32'(got[15]), 32'd255);
    chk("gxabs_held", 32'(got[18]), 32'd5);

    clear_counts();
    frame(0, 0, 0, 0, 5, 100, 0, 0, 0, 1'b0);
    drain();
    chk("mode_next_frame", 32'(got[15]), 32'd105);

    // Reset mid-frame with data in flight.
    bus.mode_i = 2'd0;
    for (int p = 0; p < 5; p++) send(7, 7);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("midrst_valid", 32'(bus.valid_o), 32'd0);
      chk("midrst_ready", 32'(bus.ready_o), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_ready_after", 32'(bus.ready_o), 32'd1);
    clear_counts();
    frame(0, 0, 0, 0, 1, 2, 0, 0, 0, 1'b0);
    drain();
    chk("midrst_sof", 32'(sofs), 32'd1);
    chk("midrst_beats", 32'(beats), 32'd36);
    chk("midrst_p5", 32'(got[15]), 32'd3);

    // Random valid/ready over three frames.
    clear_counts();
    rand_rdy = 1'b1;
    rand_vld = 1'b1;
    for (int f = 0; f < 3; f++) begin
      bus.mode_i   = 2'($urandom_range(0, 3));
      bus.thresh_i = W'($urandom_range(0, 255));
      for (int p = 0; p < LW * FH; p++) begin
        int gx, gy;
        gx = ($urandom_range(0, 9) == 0) ? -32768 : int'($urandom_range(0, 700)) - 350;
        gy = int'($urandom_range(0, 700)) - 350;
        send(gx, gy);
        if (p == 0) begin
          bus.mode_i   = 2'($urandom_range(0, 3));
          bus.thresh_i = W'($urandom_range(0, 255));
        end
      end
    end
    drain();
    rand_rdy = 1'b0;
    rand_vld = 1'b0;
    drain();
    chk("rand_beats", 32'(beats), 32'd108);
    chk("rand_sof", 32'(sofs), 32'd3);
    chk("rand_eol", 32'(eols), 32'd9);
    chk("rand_done", 32'(fds), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
